id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between the instruction decoder and the execute stage.
- Captures the decoded control bundle, register operands, immediate and PC from ID each cycle.
- Detects load-use hazards and squashes the instruction in ID when EX redirects the PC.
- Drives stall to PC/IF-ID, inserts bubbles into EX, and keeps a saturating count of bubbles.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.
- CNT_W, 32, width of the bubble performance counter.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rs1_used, id_rs2_used  in  1 each  instruction reads rs1/rs2
- id_RegWrite, id_MemWrite, id_ALUSrc  in  1 each  decoded controls
- id_ALUOp  in  5  decoded ALU operation
- id_NPCOp  in  3  decoded next-PC operation
- id_WDSel  in  2  write-back select (01 = memory)
- id_dm_ctrl  in  3  data memory access width/sign
- id_rd1, id_rd2, id_imm  in  XLEN each  register-file data, extended immediate
- ex_flush  in  1  EX resolved a taken branch/jump this cycle
- stall  out  1  hold PC and IF/ID register this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN each  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
- ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_ALUOp, ex_NPCOp, ex_WDSel, ex_dm_ctrl  out  as inputs  registered controls
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (rstn=0 at a clk edge): every ex_* output is 0, ex_valid=0, bubble_cnt=0. stall is combinational and is 0 while ex_valid=0.
- load_use (combinational) = ex_valid & ex_WDSel==2'b01 & ex_rd!=0 & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- stall = load_use & ~ex_flush.
- Each clk edge, in priority order:
  1. Reset.
  2. ex_flush=1 -> bubble.
  3. load_use=1 -> bubble.
  4. Otherwise -> capture all id_* into ex_*, with ex_valid=id_valid.
- Bubble: ex_valid=0, and ex_RegWrite, ex_MemWrite, ex_NPCOp, ex_WDSel, ex_dm_ctrl, ex_ALUOp, ex_ALUSrc, ex_rd are all 0. Data fields (pc, rd1, rd2, imm, rs1, rs2) also load 0.
- Latency: one cycle from ID to EX. stall lasts exactly one cycle per load-use event, because the following bubble clears ex_valid.
- Flush together with load-use: flush wins. stall=0, so the redirected fetch proceeds and no extra bubble is counted.
- id_valid=0 with no hazard: captured as-is. ex_valid=0, and the id_* controls are still captured as presented (not zeroed). EX qualifies all side effects with ex_valid.
- x0 destination: never hazards (ex_rd!=0 check).
- Store data from a load: rs2 of a store is a use. id_rs2_used=1 triggers a stall (no MEM-to-EX store forwarding here).
- bubble_cnt: +1 on every edge that inserts a bubble for flush or load_use. Saturates at all-ones with no wrap. Unaffected by id_valid=0 passes.
- No internal FSM beyond the register. Operation is stateless apart from ex_* and bubble_cnt. Reset mid-stall clears stall on the next cycle because ex_valid becomes 0.

Decomposition:
- Shared package/header holds:
  - WDSel encodings (FromALU 00, FromMEM 01, FromPC 10).
  - NPCOp encodings (PLUS4 000, BRANCH 001, JUMP 010, JALR 100).
  - Bubble value constants for each control field.
- One sub-module, hazard_detect (purely combinational load_use/stall), so it can be reused by a forwarding unit.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with id_valid=1, id_RegWrite=1 -> all ex_* = 0, bubble_cnt=0, stall=0.
- Straight capture: add x3,x1,x2 (ALUOp=00011, RegWrite=1, id_pc=0x10) -> next cycle ex_valid=1, ex_rd=3, ex_ALUOp=00011, ex_pc=0x10, stall=0.
- Load-use:
  - Setup: lw x5 is in EX (WDSel=01, rd=5); ID holds add x6,x5,x1 with rs1_used=1.
  - Required: stall=1 for one cycle; next edge ex_valid=0 and ex_RegWrite=0; bubble_cnt=1.
  - Following cycle: stall=0 and the add is captured.
- Load to x0 (ex_rd=0) followed by a use of x0 -> stall=0, no bubble, bubble_cnt unchanged.
- Flush and load-use in the same cycle -> stall=0, ex_valid=0 next cycle, bubble_cnt increments by exactly 1.
- Counter saturation: use CNT_W=4 and force 17 flushes -> bubble_cnt=4'hF after the 15th and stays 4'hF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and bubble constants for the ID/EX pipeline register
// and its hazard logic.
package id_ex_stage_pkg;

  localparam int REG_IDX_W = 5;

  // Write-back source select
  localparam logic [1:0] WDSEL_FROM_ALU = 2'b00;
  localparam logic [1:0] WDSEL_FROM_MEM = 2'b01;
  localparam logic [1:0] WDSEL_FROM_PC  = 2'b10;

  // Next-PC operation
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // Control values loaded into EX when a bubble is inserted
  localparam logic       BUBBLE_REG_WRITE = 1'b0;
  localparam logic       BUBBLE_MEM_WRITE = 1'b0;
  localparam logic       BUBBLE_ALU_SRC   = 1'b0;
  localparam logic [4:0] BUBBLE_ALU_OP    = 5'b00000;
  localparam logic [2:0] BUBBLE_NPC_OP    = NPC_PLUS4;
  localparam logic [1:0] BUBBLE_WDSEL     = WDSEL_FROM_ALU;
  localparam logic [2:0] BUBBLE_DM_CTRL   = 3'b000;
  localparam logic [4:0] BUBBLE_RD        = 5'b00000;

  // What the EX register loads on the next edge
  typedef enum logic [1:0] {
    EX_LOAD_RESET   = 2'b00,
    EX_LOAD_BUBBLE  = 2'b01,
    EX_LOAD_CAPTURE = 2'b10
  } ex_load_e;

  function automatic logic is_load_wb(input logic [1:0] wdsel);
    return (wdsel == WDSEL_FROM_MEM);
  endfunction

  function automatic logic src_hit(input logic used,
                                   input logic [REG_IDX_W-1:0] rs,
                                   input logic [REG_IDX_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detection; kept standalone so a forwarding unit
// can reuse the same hit logic.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                 ex_valid,
  input  logic [1:0]           ex_wdsel,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 ex_flush,
  output logic                 load_use,
  output logic                 stall
);

  logic ex_is_load_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  // A load writing x0 never creates a dependency
  assign ex_is_load_s = ex_valid && is_load_wb(ex_wdsel) && (ex_rd != 5'd0);
  assign rs1_hit_s    = src_hit(id_rs1_used, id_rs1, ex_rd);
  assign rs2_hit_s    = src_hit(id_rs2_used, id_rs2, ex_rd);
  assign load_use     = ex_is_load_s && id_valid && (rs1_hit_s || rs2_hit_s);
  assign stall        = load_use && !ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded bundle, inserts bubbles on
// redirect or load-use, and counts inserted bubbles with saturation.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_RegWrite,
  input  logic             id_MemWrite,
  input  logic             id_ALUSrc,
  input  logic [4:0]       id_ALUOp,
  input  logic [2:0]       id_NPCOp,
  input  logic [1:0]       id_WDSel,
  input  logic [2:0]       id_dm_ctrl,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             ex_flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_RegWrite,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc,
  output logic [4:0]       ex_ALUOp,
  output logic [2:0]       ex_NPCOp,
  output logic [1:0]       ex_WDSel,
  output logic [2:0]       ex_dm_ctrl,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic     load_use_s;
  ex_load_e ex_load_s;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_wdsel    (ex_WDSel),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_flush    (ex_flush),
    .load_use    (load_use_s),
    .stall       (stall)
  );

  // Select what EX loads next; a flush outranks a load-use bubble
  always_comb begin
    ex_load_s = EX_LOAD_CAPTURE;
    if (!rstn) begin
      ex_load_s = EX_LOAD_RESET;
    end else if (ex_flush || load_use_s) begin
      ex_load_s = EX_LOAD_BUBBLE;
    end else begin
      ex_load_s = EX_LOAD_CAPTURE;
    end
  end

  // EX pipeline register
  always_ff @(posedge clk) begin
    case (ex_load_s)
      EX_LOAD_CAPTURE: begin
        ex_valid    <= id_valid;
        ex_pc       <= id_pc;
        ex_rd1      <= id_rd1;
        ex_rd2      <= id_rd2;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_RegWrite <= id_RegWrite;
        ex_MemWrite <= id_MemWrite;
        ex_ALUSrc   <= id_ALUSrc;
        ex_ALUOp    <= id_ALUOp;
        ex_NPCOp    <= id_NPCOp;
        ex_WDSel    <= id_WDSel;
        ex_dm_ctrl  <= id_dm_ctrl;
      end
      EX_LOAD_RESET: begin
        ex_valid    <= 1'b0;
        ex_pc       <= {XLEN{1'b0}};
        ex_rd1      <= {XLEN{1'b0}};
        ex_rd2      <= {XLEN{1'b0}};
        ex_imm      <= {XLEN{1'b0}};
        ex_rs1      <= 5'd0;
        ex_rs2      <= 5'd0;
        ex_rd       <= 5'd0;
        ex_RegWrite <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_ALUOp    <= 5'd0;
        ex_NPCOp    <= 3'd0;
        ex_WDSel    <= 2'd0;
        ex_dm_ctrl  <= 3'd0;
      end
      default: begin
        // Bubble; data fields are cleared too so EX never sees stale operands
        ex_valid    <= 1'b0;
        ex_pc       <= {XLEN{1'b0}};
        ex_rd1      <= {XLEN{1'b0}};
        ex_rd2      <= {XLEN{1'b0}};
        ex_imm      <= {XLEN{1'b0}};
        ex_rs1      <= 5'd0;
        ex_rs2      <= 5'd0;
        ex_rd       <= BUBBLE_RD;
        ex_RegWrite <= BUBBLE_REG_WRITE;
        ex_MemWrite <= BUBBLE_MEM_WRITE;
        ex_ALUSrc   <= BUBBLE_ALU_SRC;
        ex_ALUOp    <= BUBBLE_ALU_OP;
        ex_NPCOp    <= BUBBLE_NPC_OP;
        ex_WDSel    <= BUBBLE_WDSEL;
        ex_dm_ctrl  <= BUBBLE_DM_CTRL;
      end
    endcase
  end

  // Saturating count of inserted bubbles
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if ((ex_load_s == EX_LOAD_BUBBLE) && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule
